gc_recover_fifo: RTL and testbench
==================================

# gc_recover_fifo

Circular FIFO of invalidated flash blocks awaiting garbage collection. Sits directly upstream of the garbage collector. The remapping table pushes each block it marks invalid; the head entry is presented to the collector as `recover_blk` qualified by `fifo_recover_en`. The collector pops it once the block's erase has been issued. The block also tracks occupancy and provides sticky overflow/underflow error flags to the overall controller.

## Interface
- `DEPTH`, 16: number of entries; power of two, minimum 2.
- `BLK_W`, 12: block address width; equals the width of `block_t` in the shared types package.

- `CLK`  in  1: clock; all state updates on the rising edge.
- `nRST`  in  1: synchronous, active-low reset.
- `push`  in  1: remapping table presents an invalidated block this cycle.
- `push_blk`  in  BLK_W: block address to enqueue.
- `pop`  in  1: collector consumes the head entry.
- `flush`  in  1: controller discards all entries (GC re-init).
- `recover_blk`  out  BLK_W: head entry; 0 when empty.
- `fifo_recover_en`  out  1: head entry valid (count != 0).
- `full`  out  1: count == DEPTH.
- `count`  out  log2(DEPTH)+1: current occupancy.
- `overflow`  out  1: sticky; a push was dropped because the FIFO was full.
- `underflow`  out  1: sticky; a pop was received while empty.
- `dup_hit`  out  1: one-cycle pulse; a push was rejected as a duplicate (macro only).

## Operation
- Storage is DEPTH x BLK_W registers with `wr_ptr` and `rd_ptr` of log2(DEPTH) bits each. The pointers wrap naturally from DEPTH-1 to 0. A separate `count` register is kept; `empty`, `full` and `fifo_recover_en` are decoded from it.
- Show-ahead read: `recover_blk` = mem[rd_ptr] when count != 0, else 0. There is no read latency.
- Effective pop = `pop` && count != 0. Effective push = `push` && (count < DEPTH || effective pop) && not a duplicate.
- Each cycle, in priority order:
  1. `flush`: pointers, count, `overflow` and `underflow` are set to 0. `push` and `pop` are ignored. Memory contents are don't-care.
  2. Otherwise, the effective push writes mem[wr_ptr] and advances `wr_ptr`. The effective pop advances `rd_ptr`. `count` changes by +1, -1 or 0.
- Full with push+pop in the same cycle: both are accepted; count stays at DEPTH.
- Empty with push+pop in the same cycle: the pop is ignored and `underflow` is set. The push is stored; count becomes 1.
- Full with push and no pop: the push is dropped, `overflow` is set to 1, and state is otherwise unchanged.
- Sticky flags are cleared only by reset or `flush`.
- Reset (including mid-operation): pointers, count, `overflow`, `underflow` and `dup_hit` are 0. All outputs read 0 / empty the cycle after `nRST` is sampled low.

## Timing
- A push sampled at edge N is visible on `recover_blk`/`fifo_recover_en` after edge N (when the FIFO was empty); fall-through latency is 1 cycle.
- A pop at edge N exposes the next entry after edge N.
- `full`, `count`, `overflow` and `underflow` are registered and update on the same edge as the event that changes them.
- `dup_hit` is registered: it is high for exactly the one cycle following the rejected push.
- The collector may hold `pop` high across consecutive cycles; each cycle with count != 0 consumes one entry.

## Configuration
- `GC_RECOVER_DUP_CHECK_EN` defined:
  - Each push compares `push_blk` against every valid entry as of the start of the cycle, including a head that is being popped the same cycle.
  - On a match, the push is not stored, count is unchanged, `dup_hit` pulses and `overflow` is unaffected.
  - The comparison is a parallel DEPTH-way equality gated by per-entry valid bits derived from the pointers and count.
- `GC_RECOVER_DUP_CHECK_EN` undefined: no comparators; `dup_hit` is tied to 0 and all non-full pushes are accepted.

## Test plan
- Reset, then push 0x005, 0x00A, 0x00F on consecutive cycles -> `count` = 3, `recover_blk` = 0x005. Three pops -> 0x00A, 0x00F, then empty with `recover_blk` = 0 and `fifo_recover_en` = 0.
- Fill with 16 entries -> `full` = 1. A push of 0x100 alone -> dropped, `overflow` = 1, count = 16. Then push 0x101 with pop in the same cycle -> count = 16 and 0x101 appears last after wrap-around.
- On an empty FIFO, pop alone -> `underflow` = 1, count = 0. Push 0x020 with pop in the same cycle -> `underflow` stays 1, count = 1, `recover_blk` = 0x020.
- Push 0x7FF, then assert `flush` together with push 0x001 -> count = 0, both sticky flags 0, `fifo_recover_en` = 0.
- With the macro defined: push 0x033 twice -> second push rejected, `dup_hit` high one cycle, count = 1. With the macro undefined: count = 2 and `dup_hit` stays 0.
- Pull `nRST` low while 5 entries are held -> the next cycle count = 0 and all outputs are 0. After release, a push of 0x044 behaves normally.

Source files
------------

// File: rtl/gc_recover_fifo.sv
// Circular FIFO of invalidated flash blocks queued for garbage collection, show-ahead head.
// Optional duplicate-push rejection is enabled by defining GC_RECOVER_DUP_CHECK_EN.
module gc_recover_fifo #(
  parameter int DEPTH = 16,
  parameter int BLK_W = 12
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       push,
  input  logic [BLK_W-1:0]           push_blk,
  input  logic                       pop,
  input  logic                       flush,
  output logic [BLK_W-1:0]           recover_blk,
  output logic                       fifo_recover_en,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow,
  output logic                       dup_hit
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [BLK_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             overflow_r;
  logic             underflow_r;
  logic             dup_hit_r;

  logic             empty_s;
  logic             full_s;
  logic             dup_s;
  logic             pop_eff_s;
  logic             push_eff_s;
  logic             overflow_set_s;
  logic             underflow_set_s;
  logic [CNT_W-1:0] count_nxt_s;

  assign empty_s = (count_r == {CNT_W{1'b0}});
  assign full_s  = (count_r == FULL_CNT);

`ifdef GC_RECOVER_DUP_CHECK_EN
  logic [DEPTH-1:0] valid_s;
  logic [DEPTH-1:0] match_s;

  // An entry is live when its distance from the head is below the occupancy.
  for (genvar g = 0; g < DEPTH; g++) begin : g_dup
    logic [PTR_W-1:0] off_s;
    assign off_s      = PTR_W'(g) - rd_ptr_r;
    assign valid_s[g] = ({1'b0, off_s} < count_r);
    assign match_s[g] = valid_s[g] && (mem_r[g] == push_blk);
  end

  assign dup_s = push && (|match_s);
`else
  assign dup_s = 1'b0;
`endif

  // Qualify push/pop and derive the sticky-flag set conditions.
  always_comb begin
    pop_eff_s       = 1'b0;
    push_eff_s      = 1'b0;
    overflow_set_s  = 1'b0;
    underflow_set_s = 1'b0;
    if (flush) begin
      pop_eff_s  = 1'b0;
      push_eff_s = 1'b0;
    end else begin
      pop_eff_s       = pop && !empty_s;
      push_eff_s      = push && !dup_s && (!full_s || pop_eff_s);
      overflow_set_s  = push && !dup_s && full_s && !pop_eff_s;
      underflow_set_s = pop && empty_s;
    end
  end

  // Occupancy moves by at most one entry per cycle.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_eff_s, pop_eff_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1'b1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1'b1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer, occupancy and status-flag registers.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
      dup_hit_r   <= 1'b0;
    end else if (flush) begin
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
      dup_hit_r   <= 1'b0;
    end else begin
      if (push_eff_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_eff_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      count_r     <= count_nxt_s;
      overflow_r  <= overflow_r | overflow_set_s;
      underflow_r <= underflow_r | underflow_set_s;
      dup_hit_r   <= dup_s;
    end
  end

  // Entry storage; contents are irrelevant outside the live window, so no reset.
  always_ff @(posedge CLK) begin
    if (nRST && push_eff_s) begin
      mem_r[wr_ptr_r] <= push_blk;
    end
  end

  assign recover_blk     = empty_s ? {BLK_W{1'b0}} : mem_r[rd_ptr_r];
  assign fifo_recover_en = !empty_s;
  assign full            = full_s;
  assign count           = count_r;
  assign overflow        = overflow_r;
  assign underflow       = underflow_r;
`ifdef GC_RECOVER_DUP_CHECK_EN
  assign dup_hit         = dup_hit_r;
`else
  assign dup_hit         = 1'b0;
`endif

endmodule

// File: tb/tb_gc_recover_fifo.sv
// Bench for gc_recover_fifo: directed scenarios then random traffic against a queue model.
module tb_gc_recover_fifo;
  localparam int DEPTH = 16;
  localparam int BLK_W = 12;
  localparam int CNT_W = 5;

  logic             CLK = 1'b0;
  logic             nRST;
  logic             push, pop, flush;
  logic [BLK_W-1:0] push_blk;
  logic [BLK_W-1:0] recover_blk;
  logic             fifo_recover_en, full, overflow, underflow, dup_hit;
  logic [CNT_W-1:0] count;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [BLK_W-1:0] mq[$];
  bit m_ov, m_un, m_dh;

  gc_recover_fifo #(.DEPTH(DEPTH), .BLK_W(BLK_W)) dut (
    .CLK(CLK), .nRST(nRST), .push(push), .push_blk(push_blk), .pop(pop), .flush(flush),
    .recover_blk(recover_blk), .fifo_recover_en(fifo_recover_en), .full(full),
    .count(count), .overflow(overflow), .underflow(underflow), .dup_hit(dup_hit)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_asserts++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"}, 32'(count), 32'(mq.size()));
    check({tag, ".head"}, 32'(recover_blk), (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
    check({tag, ".en"}, 32'(fifo_recover_en), 32'(mq.size() != 0));
    check({tag, ".full"}, 32'(full), 32'(mq.size() == DEPTH));
    check({tag, ".ovf"}, 32'(overflow), 32'(m_ov));
    check({tag, ".udf"}, 32'(underflow), 32'(m_un));
    check({tag, ".dup"}, 32'(dup_hit), 32'(m_dh));
  endtask

  // Reference behaviour: a queue with the FIFO's acceptance rules.
  task automatic model(input bit rst_v, input bit p, input logic [BLK_W-1:0] b, input bit po, input bit f);
    bit dup, pop_ok;
    dup = 1'b0;
    if (rst_v || f) begin
      mq.delete();
      m_ov = 1'b0; m_un = 1'b0; m_dh = 1'b0;
    end else begin
`ifdef GC_RECOVER_DUP_CHECK_EN
      foreach (mq[i]) if (p && mq[i] == b) dup = 1'b1;
`endif
      pop_ok = po && (mq.size() > 0);
      m_dh = dup;
      if (po && mq.size() == 0) m_un = 1'b1;
      if (p && !dup && mq.size() == DEPTH && !pop_ok) m_ov = 1'b1;
      if (pop_ok) void'(mq.pop_front());
      if (p && !dup && (mq.size() < DEPTH)) mq.push_back(b);
    end
  endtask

  task automatic cyc(input string tag, input bit p, input logic [BLK_W-1:0] b, input bit po, input bit f);
    push = p; push_blk = b; pop = po; flush = f;
    model(1'b0, p, b, po, f);
    @(posedge CLK); #1;
    push = 1'b0; pop = 1'b0; flush = 1'b0;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    nRST = 1'b0;
    model(1'b1, 1'b0, '0, 1'b0, 1'b0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    check_all(tag);
  endtask

  initial begin
    nRST = 1'b0; push = 1'b0; pop = 1'b0; flush = 1'b0; push_blk = '0;
    do_reset("reset");

    // Basic ordering
    cyc("tp1.p0", 1'b1, 12'h005, 1'b0, 1'b0);
    cyc("tp1.p1", 1'b1, 12'h00A, 1'b0, 1'b0);
    cyc("tp1.p2", 1'b1, 12'h00F, 1'b0, 1'b0);
    check("tp1.count3", 32'(count), 32'd3);
    check("tp1.head005", 32'(recover_blk), 32'h005);
    cyc("tp1.q0", 1'b0, 12'h000, 1'b1, 1'b0);
    check("tp1.head00A", 32'(recover_blk), 32'h00A);
    cyc("tp1.q1", 1'b0, 12'h000, 1'b1, 1'b0);
    check("tp1.head00F", 32'(recover_blk), 32'h00F);
    cyc("tp1.q2", 1'b0, 12'h000, 1'b1, 1'b0);
    check("tp1.empty_blk", 32'(recover_blk), 32'h0);
    check("tp1.empty_en", 32'(fifo_recover_en), 32'h0);

    // Fill, overflow, push+pop while full, wrap-around
    for (int i = 0; i < DEPTH; i++) cyc("tp2.fill", 1'b1, 12'h200 + 12'(i), 1'b0, 1'b0);
    check("tp2.full", 32'(full), 32'h1);
    cyc("tp2.drop", 1'b1, 12'h100, 1'b0, 1'b0);
    check("tp2.ovf", 32'(overflow), 32'h1);
    check("tp2.count16", 32'(count), 32'd16);
    cyc("tp2.pushpop", 1'b1, 12'h101, 1'b1, 1'b0);
    check("tp2.count16b", 32'(count), 32'd16);
    for (int i = 0; i < DEPTH - 1; i++) cyc("tp2.drain", 1'b0, 12'h000, 1'b1, 1'b0);
    check("tp2.last101", 32'(recover_blk), 32'h101);
    cyc("tp2.drain_last", 1'b0, 12'h000, 1'b1, 1'b0);

    // Underflow and push+pop while empty
    cyc("tp3.pop_empty", 1'b0, 12'h000, 1'b1, 1'b0);
    check("tp3.udf", 32'(underflow), 32'h1);
    cyc("tp3.pushpop", 1'b1, 12'h020, 1'b1, 1'b0);
    check("tp3.udf_sticky", 32'(underflow), 32'h1);
    check("tp3.count1", 32'(count), 32'd1);
    check("tp3.head020", 32'(recover_blk), 32'h020);

    // Flush wins over push
    cyc("tp4.push", 1'b1, 12'h7FF, 1'b0, 1'b0);
    cyc("tp4.flush", 1'b1, 12'h001, 1'b0, 1'b1);
    check("tp4.count0", 32'(count), 32'd0);
    check("tp4.flags", {30'd0, overflow, underflow}, 32'h0);
    check("tp4.en0", 32'(fifo_recover_en), 32'h0);

    // Duplicate push
    cyc("tp5.first", 1'b1, 12'h033, 1'b0, 1'b0);
    cyc("tp5.second", 1'b1, 12'h033, 1'b0, 1'b0);
`ifdef GC_RECOVER_DUP_CHECK_EN
    check("tp5.count1", 32'(count), 32'd1);
    check("tp5.dup_hi", 32'(dup_hit), 32'h1);
    cyc("tp5.idle", 1'b0, 12'h000, 1'b0, 1'b0);
    check("tp5.dup_lo", 32'(dup_hit), 32'h0);
`else
    check("tp5.count2", 32'(count), 32'd2);
    check("tp5.dup0", 32'(dup_hit), 32'h0);
`endif

    // Reset mid-operation
    cyc("tp6.flush", 1'b0, 12'h000, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cyc("tp6.fill", 1'b1, 12'h300 + 12'(i), 1'b0, 1'b0);
    check("tp6.count5", 32'(count), 32'd5);
    do_reset("tp6.reset");
    check("tp6.count0", 32'(count), 32'd0);
    check("tp6.blk0", 32'(recover_blk), 32'h0);
    cyc("tp6.push044", 1'b1, 12'h044, 1'b0, 1'b0);
    check("tp6.head044", 32'(recover_blk), 32'h044);
    check("tp6.count1", 32'(count), 32'd1);

    // Random traffic; narrow address range so duplicates and full/empty occur
    for (int i = 0; i < 600; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 1) begin
        do_reset("rnd.reset");
      end else begin
        cyc("rnd",
            ($urandom_range(0, 99) < 60),
            12'($urandom_range(0, 31)),
            ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 35 : 65)),
            ($urandom_range(0, 99) < 2));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
